// File: rtl/lab5_mcore_mem_req_arbiter_if.sv
// Valid/ready message channel shared by the arbiter's request and response
// ports. The master drives msg/val and samples rdy; the slave does the reverse.
interface lab5_mcore_mem_req_arbiter_if #(
    parameter int unsigned p_msg_nbits = 77
);
    logic [p_msg_nbits-1:0] msg;
    logic                   val;
    logic                   rdy;

    modport master (
        output msg,
        output val,
        input  rdy
    );

    modport slave (
        input  msg,
        input  val,
        output rdy
    );
endinterface

// File: rtl/lab5_mcore_mem_req_arbiter.sv
// Per-core memory request arbiter: shares one request port between the
// icache (requester 0) and dcache (requester 1) refill streams, tags each
// request with the requester ID in the opaque MSB, and routes responses
// back by that ID. Round-robin arbitration, grant held across downstream
// stalls, per-requester outstanding-request throttling.
//
// Request message layout  (MSB..LSB): {type[2:0], opaque, addr, len, data}
// Response message layout (MSB..LSB): {type[2:0], opaque, test[1:0], len, data}
// len is $clog2(p_data_nbits/8) bits wide.
module lab5_mcore_mem_req_arbiter #(
    parameter int unsigned p_opaque_nbits    = 8,
    parameter int unsigned p_addr_nbits      = 32,
    parameter int unsigned p_data_nbits      = 32,
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,

    lab5_mcore_mem_req_arbiter_if.slave   in0_req,
    lab5_mcore_mem_req_arbiter_if.slave   in1_req,
    lab5_mcore_mem_req_arbiter_if.master  out_req,

    lab5_mcore_mem_req_arbiter_if.slave   in_resp,
    lab5_mcore_mem_req_arbiter_if.master  out0_resp,
    lab5_mcore_mem_req_arbiter_if.master  out1_resp
);

    localparam int unsigned c_len_nbits  = $clog2(p_data_nbits / 8);
    localparam int unsigned c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits
                                         + c_len_nbits + p_data_nbits;
    localparam int unsigned c_resp_nbits = 3 + p_opaque_nbits + 2
                                         + c_len_nbits + p_data_nbits;

    // Bit position of the requester ID (opaque MSB) inside each message.
    localparam int unsigned c_req_id_bit  = p_addr_nbits + c_len_nbits
                                          + p_data_nbits + p_opaque_nbits - 1;
    localparam int unsigned c_resp_id_bit = 2 + c_len_nbits
                                          + p_data_nbits + p_opaque_nbits - 1;

    localparam logic [2:0] c_max_outstanding = 3'(p_max_outstanding);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       prio_q,     prio_d;
    logic       lock_val_q, lock_val_d;
    logic       lock_id_q,  lock_id_d;
    logic [2:0] cnt0_q,     cnt0_d;
    logic [2:0] cnt1_q,     cnt1_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic                    elig0;
    logic                    elig1;
    logic                    grant_val;
    logic                    grant_id;
    logic [c_req_nbits-1:0]  req_sel_msg;
    logic                    req_fire;

    logic                    resp_id;
    logic [c_resp_nbits-1:0] resp_msg;
    logic                    resp_fire;

    logic                    inc0;
    logic                    inc1;
    logic                    dec0;
    logic                    dec1;

    // Outstanding counter update. A request and response on the same
    // counter in one cycle cancel; a response never drives it below zero.
    function automatic logic [2:0] cnt_next(
        input logic [2:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [2:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + 3'd1;
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - 3'd1;
        end
        return nxt;
    endfunction

    // Eligibility and grant selection (locked grant overrides everything).
    always_comb begin
        elig0     = in0_req.val && (cnt0_q < c_max_outstanding);
        elig1     = in1_req.val && (cnt1_q < c_max_outstanding);
        grant_val = 1'b0;
        grant_id  = 1'b0;

        if (lock_val_q) begin
            grant_val = 1'b1;
            grant_id  = lock_id_q;
        end else if (elig0 && elig1) begin
            grant_val = 1'b1;
            grant_id  = prio_q;
        end else if (elig0) begin
            grant_val = 1'b1;
            grant_id  = 1'b0;
        end else if (elig1) begin
            grant_val = 1'b1;
            grant_id  = 1'b1;
        end

        if (!reset_n) begin
            grant_val = 1'b0;
        end
    end

    // Request path: mux the granted message, stamp the requester ID,
    // and pass downstream ready back to the granted requester only.
    always_comb begin
        req_sel_msg               = grant_id ? in1_req.msg : in0_req.msg;
        req_sel_msg[c_req_id_bit] = grant_id;

        out_req.msg = req_sel_msg;
        out_req.val = grant_val;
        in0_req.rdy = grant_val && !grant_id && out_req.rdy;
        in1_req.rdy = grant_val &&  grant_id && out_req.rdy;

        req_fire    = grant_val && out_req.rdy;
    end

    // Response path: steer by opaque MSB and clear that bit on delivery.
    always_comb begin
        resp_id                 = in_resp.msg[c_resp_id_bit];
        resp_msg                = in_resp.msg;
        resp_msg[c_resp_id_bit] = 1'b0;

        out0_resp.msg = resp_msg;
        out1_resp.msg = resp_msg;
        out0_resp.val = reset_n && in_resp.val && !resp_id;
        out1_resp.val = reset_n && in_resp.val &&  resp_id;
        in_resp.rdy   = reset_n && (resp_id ? out1_resp.rdy : out0_resp.rdy);

        resp_fire     = in_resp.val && in_resp.rdy;
    end

    // Next-state for priority, stall lock and outstanding counters.
    always_comb begin
        prio_d     = prio_q;
        lock_val_d = lock_val_q;
        lock_id_d  = lock_id_q;

        if (req_fire) begin
            prio_d     = ~grant_id;
            lock_val_d = 1'b0;
        end else if (grant_val) begin
            lock_val_d = 1'b1;
            lock_id_d  = grant_id;
        end

        inc0   = req_fire  && !grant_id;
        inc1   = req_fire  &&  grant_id;
        dec0   = resp_fire && !resp_id;
        dec1   = resp_fire &&  resp_id;
        cnt0_d = cnt_next(cnt0_q, inc0, dec0);
        cnt1_d = cnt_next(cnt1_q, inc1, dec1);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q     <= 1'b0;
            lock_val_q <= 1'b0;
            lock_id_q  <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_val_q <= lock_val_d;
            lock_id_q  <= lock_id_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

endmodule

// File: doc/lab5_mcore_mem_req_arbiter.md
# lab5_mcore_mem_req_arbiter

Per-core arbiter that shares one memory-request network port between the instruction-cache and data-cache refill streams, and steers memory responses back to the originating cache. It sits between a core's two cache memory interfaces and the request/response mem-net adapters. Arbitration is round-robin, and a grant is held while the downstream port is stalled. A requester ID is carried in the opaque MSB. Per-requester outstanding-request counters throttle each stream.

## Interface
- p_opaque_nbits, 8, mem msg opaque width; MSB is reserved for the requester ID.
- p_addr_nbits, 32, mem msg address width.
- p_data_nbits, 32, mem msg data width.
- p_max_outstanding, 4, max in-flight requests per requester (1..7).
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in0_req_msg / in0_req_val / in0_req_rdy  in/in/out  `VC_MEM_REQ_MSG_NBITS(o,a,d)`/1/1  icache request port.
- in1_req_msg / in1_req_val / in1_req_rdy  in/in/out  same widths  dcache request port.
- out_req_msg / out_req_val / out_req_rdy  out/out/in  same widths  request port toward the net adapter.
- in_resp_msg / in_resp_val / in_resp_rdy  in/in/out  `VC_MEM_RESP_MSG_NBITS(o,d)`/1/1  response from the net adapter.
- out0_resp_msg / out0_resp_val / out0_resp_rdy  out/out/in  resp width/1/1  icache response port.
- out1_resp_msg / out1_resp_val / out1_resp_rdy  out/out/in  resp width/1/1  dcache response port.

## Operation
- State elements:
  - prio: 1 bit, the preferred requester.
  - lock_val and lock_id: holds a stalled grant.
  - cnt0 and cnt1: 3-bit outstanding counters.
- Eligibility: requester i is eligible when in{i}_req_val is high and cnt{i} < p_max_outstanding.
- Grant selection:
  - If lock_val is set, grant = lock_id.
  - Otherwise, if both requesters are eligible, grant = prio.
  - Otherwise, grant goes to the single eligible requester.
  - Otherwise, there is no grant.
- out_req_val is high when a grant exists.
- out_req_msg is the granted message with opaque replaced by {grant_id, in_opaque[o-2:0]}. Type, addr, len and data pass unmodified.
- in{grant}_req_rdy = out_req_rdy. The non-granted requester's rdy = 0.
- Request fire (out_req_val & out_req_rdy):
  - prio <= ~grant_id.
  - lock_val <= 0.
  - cnt{grant} increments.
- Stall (out_req_val & ~out_req_rdy): lock_val <= 1 and lock_id <= grant_id. The grant and message are then stable until fire, even if the other requester becomes eligible.
- Response routing: id = in_resp opaque MSB.
  - out{id}_resp_val = in_resp_val. The other port's val = 0.
  - in_resp_rdy = out{id}_resp_rdy.
  - Delivered msg has the opaque MSB cleared; all other fields are unchanged.
- Response fire decrements cnt{id}. If a request fire and a response fire hit the same counter in one cycle, the counter is unchanged.
- Counters never underflow: a response with cnt{id} == 0 is still delivered, and the counter stays 0.
- Requesters must drive opaque MSB = 0. The arbiter ignores and overwrites that bit.

## Timing
- Request and response paths are combinational: zero cycles of latency and no buffering.
- Reset values (reset_n low, asynchronous):
  - prio = 0, lock_val = 0, lock_id = 0, cnt0 = cnt1 = 0.
  - While reset_n is low, all *_val and *_rdy outputs are forced to 0.
- Reset mid-transfer: the lock and counters clear immediately. After reset release, arbitration restarts with requester 0 preferred.
- Counter ceiling: when cnt{i} == p_max_outstanding, requester i is ineligible and its rdy = 0. It becomes eligible in the cycle after a response fire decrements the counter.
- A locked grant ignores eligibility. This cannot violate the limit, because the lock was taken while the requester was eligible and no fire has occurred since.
- Request and response handshakes are independent and may fire in the same cycle.

## Test plan
- Single requester:
  - Stimulus: in0 read, addr 0x00001010, opaque 0x05, out_req_rdy = 1.
  - Response: out_req_msg opaque 0x05, same cycle. Then in_resp opaque 0x05 appears on out0 with opaque 0x05, and cnt0 returns to 0.
- Contention:
  - Stimulus: both requesters continuously valid, out_req_rdy = 1.
  - Response: grants go 0,1,0,1. out opaque MSB alternates 0/1 (in1 opaque 0x12 emits 0x92). A response with opaque 0x92 goes to out1 as 0x12.
- Stall lock:
  - Stimulus: in1 granted with out_req_rdy = 0 for 3 cycles while in0 is asserted with prio = 0.
  - Response: out_req_msg stays in1's message and in0_req_rdy = 0 until fire. On the next cycle in0 is granted.
- Outstanding limit:
  - Stimulus: p_max_outstanding = 4; 4 in0 reads with no responses.
  - Response: the 5th read sees in0_req_rdy = 0 and out_req_val = 0 while in1 is idle. One response to in0 unblocks it on the next cycle.
- Simultaneous events:
  - Stimulus: an in0 request fire and an in0 response fire in the same cycle with cnt0 = 2.
  - Response: cnt0 stays 2.
- Reset mid-operation:
  - Stimulus: assert reset_n low during a locked stall with cnt1 = 3.
  - Response: all val/rdy outputs drop to 0 immediately. After release, prio = 0, no lock, and both counters are 0.
